// File: rtl/aes_pkg.sv
// Shared AES helpers: GF(2^8) arithmetic, S-box affine maps, InvMixColumns
// column function and the column-major state byte addressing.
package aes_pkg;

  localparam logic [7:0] AES_RCON_LAST = 8'h36;
  localparam logic [7:0] AES_RCON_WRAP = 8'h1b;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } dec_state_e;

  // LSB position of the byte at (row, col); row0/col0 sits in bits [127:120].
  function automatic int byte_lsb(input int row, input int col);
    return 120 - 8 * (4 * col + row);
  endfunction

  function automatic logic [7:0] gf_xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul9(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ a;
  endfunction

  function automatic logic [7:0] gf_mulb(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ gf_xtime(a) ^ a;
  endfunction

  function automatic logic [7:0] gf_muld(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ gf_xtime(gf_xtime(a)) ^ a;
  endfunction

  function automatic logic [7:0] gf_mule(input logic [7:0] a);
    return gf_xtime(gf_xtime(gf_xtime(a))) ^ gf_xtime(gf_xtime(a)) ^ gf_xtime(a);
  endfunction

  // General shift-and-add multiply, used only to build the field inverse.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = gf_xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as the S-box requires).
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] x2, x3, x12, x14, x15, x240;
    x2   = gf_mul(a, a);
    x3   = gf_mul(x2, a);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x14  = gf_mul(x12, x2);
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(x240, x14);
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  function automatic logic [7:0] sbox_affine(input logic [7:0] x);
    return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3) ^ rotl8(x, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox_affine(input logic [7:0] s);
    return rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
  endfunction

  // One column through the {0e,0b,0d,09} circulant; row0 in the MSBs.
  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] c0, c1, c2, c3;
    c0 = c[31:24];
    c1 = c[23:16];
    c2 = c[15:8];
    c3 = c[7:0];
    return {gf_mule(c0) ^ gf_mulb(c1) ^ gf_muld(c2) ^ gf_mul9(c3),
            gf_mul9(c0) ^ gf_mule(c1) ^ gf_mulb(c2) ^ gf_muld(c3),
            gf_muld(c0) ^ gf_mul9(c1) ^ gf_mule(c2) ^ gf_mulb(c3),
            gf_mulb(c0) ^ gf_muld(c1) ^ gf_mul9(c2) ^ gf_mule(c3)};
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Inverse AES S-box: field inverse of the inverse affine map.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = gf_inv(inv_sbox_affine(a_i));

endmodule

// File: rtl/sbox.sv
// Forward AES S-box: affine map of the field inverse.
module sbox
  import aes_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox_affine(gf_inv(a_i));

endmodule

// File: rtl/aes_decrypt_iter.sv
// Iterative AES-128 inverse cipher, one round per clock. Round keys are
// walked backwards from the round-10 key, so only one key register exists.
// Handshake: start is taken on an edge where busy=0; done pulses for one
// cycle with plaintext valid, and busy is already low in that cycle.
module aes_decrypt_iter
  import aes_pkg::*;
#(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key_last,
  input  logic [127:0] ciphertext,
  output logic         busy,
  output logic         done,
  output logic [127:0] plaintext
);

  dec_state_e   fsm_q;
  logic [127:0] state_q, round_key_q, plaintext_q;
  logic [7:0]   rcon_q;
  logic [3:0]   rnd_q;
  logic         busy_q, done_q;

  logic [31:0]  a0, a1, a2, a3, b0, b1, b2, b3, rot_w, sub_w;
  logic [127:0] key_d, isb, add_key, state_d;
  logic [7:0]   rcon_d;

  // Reverse key step: recover the previous round key from the current one.
  assign {a0, a1, a2, a3} = round_key_q;
  assign b3    = a3 ^ a2;
  assign b2    = a2 ^ a1;
  assign b1    = a1 ^ a0;
  assign rot_w = {b3[23:0], b3[31:24]};

  for (genvar k = 0; k < 4; k++) begin : g_subword
    sbox u_sbox (.a_i(rot_w[8*k +: 8]), .y_o(sub_w[8*k +: 8]));
  end

  assign b0     = a0 ^ sub_w ^ {rcon_q, 24'h0};
  assign key_d  = {b0, b1, b2, b3};
  assign rcon_d = (rcon_q == AES_RCON_WRAP) ? 8'h80 : {1'b0, rcon_q[7:1]};

  // InvShiftRows is pure wiring into the inverse S-boxes; row r rotates right by r.
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int DST = byte_lsb(r, c);
      localparam int SRC = byte_lsb(r, (c + 4 - r) % 4);
      inv_sbox u_inv_sbox (.a_i(state_q[SRC +: 8]), .y_o(isb[DST +: 8]));
    end
    assign state_d[127-32*c -: 32] = inv_mix_col(add_key[127-32*c -: 32]);
  end

  assign add_key = isb ^ key_d;

  // Control FSM and datapath registers; done defaults low so it only pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_q       <= ST_IDLE;
      state_q     <= '0;
      round_key_q <= '0;
      plaintext_q <= '0;
      rcon_q      <= '0;
      rnd_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (fsm_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ciphertext ^ key_last;
            round_key_q <= key_last;
            rcon_q      <= AES_RCON_LAST;
            rnd_q       <= 4'(NR - 1);
            busy_q      <= 1'b1;
            fsm_q       <= ST_ROUND;
          end
        end
        ST_ROUND: begin
          state_q     <= state_d;
          round_key_q <= key_d;
          rcon_q      <= rcon_d;
          rnd_q       <= rnd_q - 4'd1;
          if (rnd_q == 4'd1) fsm_q <= ST_FINAL;
        end
        ST_FINAL: begin
          plaintext_q <= add_key;
          done_q      <= 1'b1;
          busy_q      <= 1'b0;
          fsm_q       <= ST_IDLE;
        end
        default: fsm_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign plaintext = plaintext_q;

  // The round counter never exceeds its load value, and done never overlaps busy.
  a_rnd_range: assert property (@(posedge clk) disable iff (!rst) rnd_q <= 4'(NR - 1));
  a_done_idle: assert property (@(posedge clk) disable iff (!rst) done_q |-> !busy_q);

endmodule

// File: tb/tb_aes_decrypt_iter.sv
// Directed and random round-trip bench for aes_decrypt_iter.
module tb_aes_decrypt_iter;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [127:0] key_last = '0;
  logic [127:0] ciphertext = '0;
  logic         busy, done;
  logic [127:0] plaintext;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  aes_decrypt_iter dut (
    .clk(clk), .rst(rst), .start(start), .key_last(key_last),
    .ciphertext(ciphertext), .busy(busy), .done(done), .plaintext(plaintext)
  );

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  vec_t vecs[2];
  logic [7:0] sbox_t [256];

  // ---------------- reference model ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int unsigned n);
    logic [15:0] d;
    d = {x, x} << n;
    return d[15:8];
  endfunction

  // Build the S-box by walking the generator 3 and its inverse together.
  task automatic init_sbox();
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ xt(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
      sbox_t[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [7:0] gb(input logic [127:0] b, input int i);
    logic [127:0] t;
    t = b << (8 * i);
    return t[127:120];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox_t[w[31:24]], sbox_t[w[23:16]], sbox_t[w[15:8]], sbox_t[w[7:0]]};
  endfunction

  function automatic logic [127:0] enc_round(input logic [127:0] s, input logic [127:0] rk,
                                             input bit do_mix);
    logic [127:0] sh, mx;
    logic [7:0] x0, x1, x2, x3;
    sh = '0;
    for (int i = 0; i < 16; i++)
      sh = {sh[119:0], sbox_t[gb(s, (i % 4) + 4 * (((i / 4) + (i % 4)) % 4))]};
    if (!do_mix) return sh ^ rk;
    mx = '0;
    for (int c = 0; c < 4; c++) begin
      x0 = gb(sh, 4*c); x1 = gb(sh, 4*c+1); x2 = gb(sh, 4*c+2); x3 = gb(sh, 4*c+3);
      mx = {mx[95:0],
            xt(x0) ^ xt(x1) ^ x1 ^ x2 ^ x3,
            x0 ^ xt(x1) ^ xt(x2) ^ x2 ^ x3,
            x0 ^ x1 ^ xt(x2) ^ xt(x3) ^ x3,
            xt(x0) ^ x0 ^ x1 ^ x2 ^ xt(x3)};
    end
    return mx ^ rk;
  endfunction

  task automatic model_encrypt(input logic [127:0] key, input logic [127:0] pt,
                               output logic [127:0] ct, output logic [127:0] k10);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    logic [127:0] s;
    {w[0], w[1], w[2], w[3]} = key;
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
        rc = xt(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    s = pt ^ key;
    for (int r = 1; r <= 9; r++)
      s = enc_round(s, {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]}, 1'b1);
    k10 = {w[40], w[41], w[42], w[43]};
    ct = enc_round(s, k10, 1'b0);
  endtask

  // ---------------- driver and checker tasks ----------------
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int edges);
    edges = -1;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (done === 1'b1) begin
        edges = n;
        break;
      end
    end
  endtask

  task automatic accept(input logic [127:0] key, input logic [127:0] ct);
    start = 1'b1;
    key_last = key;
    ciphertext = ct;
    tick();
    start = 1'b0;
  endtask

  task automatic run_vec(input string name, input logic [127:0] key,
                         input logic [127:0] ct, input logic [127:0] pt);
    int lat;
    accept(key, ct);
    check({name, "_busy"}, 128'(busy), 128'(1));
    wait_done(lat);
    check({name, "_latency"}, 128'(lat), 128'(10));
    check({name, "_pt"}, plaintext, pt);
    tick();
    check({name, "_done_width"}, 128'(done), 128'(0));
    check({name, "_idle"}, 128'(busy), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2, spurious;
    logic [127:0] rk, rp, rc, rk10;

    init_sbox();
    vecs[0] = '{key: 128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
                ct:  128'h3925841d02dc09fbdc118597196a0b32,
                pt:  128'h3243f6a8885a308d313198a2e0370734};
    vecs[1] = '{key: 128'h13111d7fe3944a17f307a78b4d2b30c5,
                ct:  128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                pt:  128'h00112233445566778899aabbccddeeff};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset_busy", 128'(busy), 128'(0));
    check("reset_done", 128'(done), 128'(0));
    check("reset_pt", plaintext, 128'(0));
    rst = 1'b1;
    tick();

    // Table-driven known-answer vectors
    for (int i = 0; i < 2; i++)
      run_vec($sformatf("kat%0d", i), vecs[i].key, vecs[i].ct, vecs[i].pt);

    // Back-to-back: second start issued in the done cycle
    accept(vecs[0].key, vecs[0].ct);
    wait_done(lat);
    check("b2b_first_latency", 128'(lat), 128'(10));
    check("b2b_first_pt", plaintext, vecs[0].pt);
    accept(vecs[1].key, vecs[1].ct);
    check("b2b_second_busy", 128'(busy), 128'(1));
    wait_done(lat2);
    check("b2b_done_spacing", 128'(lat2 + 1), 128'(11));
    check("b2b_second_pt", plaintext, vecs[1].pt);
    tick();

    // start held high, inputs changed at T3
    start = 1'b1;
    key_last = vecs[0].key;
    ciphertext = vecs[0].ct;
    tick();
    tick(); tick(); tick();
    key_last = vecs[1].key;
    ciphertext = vecs[1].ct;
    wait_done(lat);
    check("held_latency", 128'(lat), 128'(7));
    check("held_pt", plaintext, vecs[0].pt);
    wait_done(lat2);
    start = 1'b0;
    check("held_spacing", 128'(lat2), 128'(11));
    check("held_second_pt", plaintext, vecs[1].pt);
    tick();
    check("held_no_third", 128'(busy), 128'(0));

    // Asynchronous reset in the middle of a block
    accept(vecs[0].key, vecs[0].ct);
    repeat (5) tick();
    #2;
    rst = 1'b0;
    #1;
    check("midreset_busy", 128'(busy), 128'(0));
    check("midreset_done", 128'(done), 128'(0));
    check("midreset_pt", plaintext, 128'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    tick();
    spurious = 0;
    for (int n = 0; n < 15; n++) begin
      if (done !== 1'b0) spurious++;
      tick();
    end
    check("midreset_no_done", 128'(spurious), 128'(0));
    run_vec("after_reset", vecs[0].key, vecs[0].ct, vecs[0].pt);

    // Random round trip through the reference encryptor
    for (int n = 0; n < 1000; n++) begin
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      model_encrypt(rk, rp, rc, rk10);
      accept(rk10, rc);
      wait_done(lat);
      check("rand_latency", 128'(lat), 128'(10));
      check("rand_pt", plaintext, rp);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
